sdram_write: RTL

Write-side datapath of the wishbone SDRAM slave. It drains 32-bit words from one of two ping-pong write FIFOs and writes each word to SDRAM as two consecutive 16-bit halfwords, top half first, using full-page bursts. It arbitrates for refresh by yielding whenever `auto_refresh` is raised. It sits beside `sdram_read` under the SDRAM controller, which multiplexes both blocks' command, address and bank outputs onto the device pins.

---
 rtl/sdram_write_pkg.sv | 50 +++++
 rtl/sdram_write.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/sdram_write_pkg.sv
// Shared SDRAM write-path definitions: command encodings, timing constants, FSM states, address layout.
package sdram_write_pkg;

    localparam int unsigned CMD_W   = 3;
    localparam int unsigned ADDR_W  = 22;
    localparam int unsigned ROW_W   = 12;
    localparam int unsigned COL_W   = 8;
    localparam int unsigned BANK_W  = 2;
    localparam int unsigned DQ_W    = 16;
    localparam int unsigned DQM_W   = 2;
    localparam int unsigned COUNT_W = 24;
    localparam int unsigned DELAY_W = 16;
    localparam int unsigned FIFO_W  = 32;
    localparam int unsigned MASK_W  = 4;
    localparam int unsigned NFIFO   = 2;

    // {RAS,CAS,WE}
    localparam logic [CMD_W-1:0] SDRAM_CMD_NOP       = 3'b111;
    localparam logic [CMD_W-1:0] SDRAM_CMD_ACTIVE    = 3'b011;
    localparam logic [CMD_W-1:0] SDRAM_CMD_WRITE     = 3'b100;
    localparam logic [CMD_W-1:0] SDRAM_CMD_TERMINATE = 3'b110;
    localparam logic [CMD_W-1:0] SDRAM_CMD_PRECHARGE = 3'b010;

    localparam logic [DELAY_W-1:0] T_RCD = 16'd2;
    localparam logic [DELAY_W-1:0] T_WR  = 16'd2;
    localparam logic [DELAY_W-1:0] T_RP  = 16'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACTIVATE,
        ST_WRITE_COMMAND,
        ST_WRITE_BOTTOM,
        ST_WRITE_TOP,
        ST_BURST_TERMINATE,
        ST_PRECHARGE
    } state_t;

    typedef struct packed {
        logic [BANK_W-1:0] bank;
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
    } sdram_addr_t;

    // FIFO 0 has priority when both hold a block
    function automatic logic [NFIFO-1:0] pick_fifo(input logic [NFIFO-1:0] ready);
        return ready[0] ? 2'b01 : 2'b10;
    endfunction

endpackage

// File: rtl/sdram_write.sv
// Write-side SDRAM datapath: drains 32-bit ping-pong FIFO words as top/bottom 16-bit halfword bursts.
// Optional SDRAM_WRITE_MASK_EN drives DQM from the FIFO byte enables; otherwise DQM stays 2'b00.
module sdram_write
    import sdram_write_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    output logic [CMD_W-1:0]    o_command,
    output logic [ROW_W-1:0]    o_address,
    output logic [BANK_W-1:0]   o_bank,
    output logic [DQ_W-1:0]     o_data_out,
    output logic [DQM_W-1:0]    o_data_mask,
    input  logic                i_enable,
    output logic                o_idle,
    input  logic                i_auto_refresh,
    output logic                o_wait_for_refresh,
    input  logic [ADDR_W-1:0]   i_app_address,
    input  logic [NFIFO-1:0]    i_fifo_ready,
    output logic [NFIFO-1:0]    o_fifo_activate,
    input  logic [COUNT_W-1:0]  i_fifo_size,
    input  logic [FIFO_W-1:0]   i_fifo_data,
    input  logic [MASK_W-1:0]   i_fifo_mask,
    output logic                o_fifo_strobe
);

    state_t              r_state;
    logic [DELAY_W-1:0]  r_delay;
    logic [ADDR_W-1:0]   r_write_address;
    logic [COUNT_W-1:0]  r_count;

    sdram_addr_t         w_cur;
    logic [ADDR_W-1:0]   w_next_address;
    sdram_addr_t         w_next;
    logic                w_last;
    logic [DQM_W-1:0]    w_mask_top;
    logic [DQM_W-1:0]    w_mask_bot;

    assign w_cur          = sdram_addr_t'(r_write_address);
    assign w_next_address = r_write_address + ADDR_W'(2);
    assign w_next         = sdram_addr_t'(w_next_address);

    // Burst ends on the last dword, a lost session, a refresh request or a page wrap
    assign w_last = (r_count == COUNT_W'(1)) || !i_enable || i_auto_refresh
                    || (w_next.col == '0);

`ifdef SDRAM_WRITE_MASK_EN
    assign w_mask_top = ~i_fifo_mask[3:2];
    assign w_mask_bot = ~i_fifo_mask[1:0];
`else
    logic w_unused_mask;
    assign w_unused_mask = ^i_fifo_mask;
    assign w_mask_top    = '0;
    assign w_mask_bot    = '0;
`endif

    assign o_idle = (r_delay == '0) && ((r_state == ST_IDLE) || (r_state == ST_WAIT));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state            <= ST_IDLE;
            r_delay            <= '0;
            r_write_address    <= '0;
            r_count            <= '0;
            o_command          <= SDRAM_CMD_NOP;
            o_address          <= '0;
            o_bank             <= '0;
            o_data_out         <= '0;
            o_data_mask        <= '0;
            o_fifo_activate    <= '0;
            o_fifo_strobe      <= 1'b0;
            o_wait_for_refresh <= 1'b0;
        end else begin
            o_command          <= SDRAM_CMD_NOP;
            o_fifo_strobe      <= 1'b0;
            o_wait_for_refresh <= 1'b0;

            // DQ/DQM follow the state even while the delay counter holds it
            case (r_state)
                ST_WRITE_COMMAND, ST_WRITE_TOP: begin
                    o_data_out  <= i_fifo_data[31:16];
                    o_data_mask <= w_mask_top;
                end
                ST_WRITE_BOTTOM: begin
                    o_data_out  <= i_fifo_data[15:0];
                    o_data_mask <= w_mask_bot;
                end
                default: ;
            endcase

            if (r_delay != '0) begin
                r_delay <= r_delay - DELAY_W'(1);
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        o_fifo_activate    <= '0;
                        o_wait_for_refresh <= 1'b1;
                        if (i_enable && (i_fifo_ready != '0)) begin
                            r_write_address <= i_app_address;
                            r_count         <= i_fifo_size;
                            o_fifo_activate <= pick_fifo(i_fifo_ready);
                            r_state         <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (i_auto_refresh) begin
                            o_wait_for_refresh <= 1'b1;
                        end else if (!i_enable) begin
                            r_state <= ST_IDLE;
                        end else if ((r_count == '0) && (o_fifo_activate != '0)) begin
                            o_fifo_activate <= '0;
                        end else if (o_fifo_activate != '0) begin
                            r_state <= ST_ACTIVATE;
                        end else if (i_fifo_ready != '0) begin
                            o_fifo_activate <= pick_fifo(i_fifo_ready);
                            r_count         <= i_fifo_size;
                            r_state         <= ST_ACTIVATE;
                        end
                    end
                    ST_ACTIVATE: begin
                        if (i_auto_refresh) begin
                            r_state <= ST_WAIT;
                        end else begin
                            o_command <= SDRAM_CMD_ACTIVE;
                            o_bank    <= w_cur.bank;
                            o_address <= w_cur.row;
                            r_delay   <= T_RCD;
                            r_state   <= ST_WRITE_COMMAND;
                        end
                    end
                    ST_WRITE_COMMAND: begin
                        o_command <= SDRAM_CMD_WRITE;
                        o_address <= ROW_W'(w_cur.col);
                        r_state   <= ST_WRITE_BOTTOM;
                    end
                    ST_WRITE_BOTTOM: begin
                        o_fifo_strobe   <= 1'b1;
                        r_write_address <= w_next_address;
                        r_count         <= r_count - COUNT_W'(1);
                        r_state         <= w_last ? ST_BURST_TERMINATE : ST_WRITE_TOP;
                    end
                    ST_WRITE_TOP: begin
                        r_state <= ST_WRITE_BOTTOM;
                    end
                    ST_BURST_TERMINATE: begin
                        o_command <= SDRAM_CMD_TERMINATE;
                        r_delay   <= T_WR;
                        r_state   <= ST_PRECHARGE;
                    end
                    ST_PRECHARGE: begin
                        o_command <= SDRAM_CMD_PRECHARGE;
                        r_delay   <= T_RP;
                        r_state   <= ST_WAIT;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
